// File: rtl/interfaz_rx.sv
// Purpose : assembles a 3-byte UART frame (operand A, operand B, opcode) into
//           one coherent set of registered ALU operands with a valid pulse.
// Latency : o_valid rises one cycle after the opcode byte is sampled; o_timeout
//           rises one cycle after the inter-byte gap expires.
// Backpressure: none; every i_done_rx pulse is consumed in the cycle it arrives.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-low reset
//   i_data     byte from the UART receiver, qualified by i_done_rx
//   i_done_rx  one-cycle strobe: i_data holds a complete byte
//   o_dato_a   operand A to the ALU (held until the next complete frame)
//   o_dato_b   operand B to the ALU (held until the next complete frame)
//   o_opcode   opcode to the ALU, low NB_OPCODE bits of the third byte
//   o_valid    one-cycle pulse: a new frame is present on the ALU outputs
//   o_timeout  one-cycle pulse: a partial frame was discarded
module interfaz_rx #(
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned NB_OPCODE = 6,
  parameter int unsigned TIMEOUT   = 50000,
  parameter int unsigned NB_TIMER  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NB_DATA-1:0]   i_data,
  input  logic                 i_done_rx,
  output logic [NB_DATA-1:0]   o_dato_a,
  output logic [NB_DATA-1:0]   o_dato_b,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic                 o_valid,
  output logic                 o_timeout
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    VALID   = 2'd3
  } state_t;

  // A zero TIMEOUT disables expiry entirely; CNT_LAST is then never consulted.
  localparam bit                  TO_EN    = (TIMEOUT != 0);
  localparam logic [NB_TIMER-1:0] CNT_LAST = NB_TIMER'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [NB_TIMER-1:0] CNT_MAX  = '1;

  state_t                 state_q,   state_d;
  logic [NB_DATA-1:0]     a_buf_q,   a_buf_d;
  logic [NB_DATA-1:0]     b_buf_q,   b_buf_d;
  logic [NB_TIMER-1:0]    cnt_q,     cnt_d;
  logic [NB_DATA-1:0]     dato_a_q,  dato_a_d;
  logic [NB_DATA-1:0]     dato_b_q,  dato_b_d;
  logic [NB_OPCODE-1:0]   opcode_q,  opcode_d;
  logic                   timeout_q, timeout_d;

  logic                   gap_expired;
  logic [NB_TIMER-1:0]    cnt_inc;

  // Expiry only when no byte arrives this cycle: a byte landing on the last
  // allowed cycle wins and the frame continues.
  assign gap_expired = TO_EN && (cnt_q == CNT_LAST) && !i_done_rx;

  // Saturating increment, relevant when the timeout is disabled and a frame
  // stalls forever.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    a_buf_d   = a_buf_q;
    b_buf_d   = b_buf_q;
    cnt_d     = cnt_q;
    dato_a_d  = dato_a_q;
    dato_b_d  = dato_b_q;
    opcode_d  = opcode_q;
    timeout_d = 1'b0;

    case (state_q)
      WAIT_A: begin
        // Idle between frames: no gap is measured here.
        cnt_d = '0;
        if (i_done_rx) begin
          a_buf_d = i_data;
          state_d = WAIT_B;
        end
      end

      WAIT_B: begin
        if (i_done_rx) begin
          b_buf_d = i_data;
          cnt_d   = '0;
          state_d = WAIT_OP;
        end else if (gap_expired) begin
          // Shadow buffers are left as-is; they are overwritten by the next frame.
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = WAIT_A;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_OP: begin
        if (i_done_rx) begin
          // All three ALU fields update together so the ALU never sees a mix
          // of two frames.
          dato_a_d = a_buf_q;
          dato_b_d = b_buf_q;
          opcode_d = i_data[NB_OPCODE-1:0];
          cnt_d    = '0;
          state_d  = VALID;
        end else if (gap_expired) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = WAIT_A;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      VALID: begin
        cnt_d = '0;
        // A byte arriving during the valid pulse already starts the next frame.
        if (i_done_rx) begin
          a_buf_d = i_data;
          state_d = WAIT_B;
        end else begin
          state_d = WAIT_A;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = WAIT_A;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= WAIT_A;
      a_buf_q   <= '0;
      b_buf_q   <= '0;
      cnt_q     <= '0;
      dato_a_q  <= '0;
      dato_b_q  <= '0;
      opcode_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_buf_q   <= a_buf_d;
      b_buf_q   <= b_buf_d;
      cnt_q     <= cnt_d;
      dato_a_q  <= dato_a_d;
      dato_b_q  <= dato_b_d;
      opcode_q  <= opcode_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_dato_a  = dato_a_q;
  assign o_dato_b  = dato_b_q;
  assign o_opcode  = opcode_q;
  // Decoded straight from the state register: high for exactly the VALID cycle.
  assign o_valid   = (state_q == VALID);
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_interfaz_rx.sv
module tb_interfaz_rx;

  localparam int NB_DATA   = 8;
  localparam int NB_OPCODE = 6;
  localparam int TIMEOUT   = 20;
  localparam int NB_TIMER  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NB_DATA-1:0]   data;
  logic                 done;
  logic [NB_DATA-1:0]   o_dato_a;
  logic [NB_DATA-1:0]   o_dato_b;
  logic [NB_OPCODE-1:0] o_opcode;
  logic                 o_valid;
  logic                 o_timeout;

  interfaz_rx #(
    .NB_DATA  (NB_DATA),
    .NB_OPCODE(NB_OPCODE),
    .TIMEOUT  (TIMEOUT),
    .NB_TIMER (NB_TIMER)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_data   (data),
    .i_done_rx(done),
    .o_dato_a (o_dato_a),
    .o_dato_b (o_dato_b),
    .o_opcode (o_opcode),
    .o_valid  (o_valid),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit                   is_frame;
    logic [NB_DATA-1:0]   a;
    logic [NB_DATA-1:0]   b;
    logic [NB_OPCODE-1:0] op;
    int                   cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_a"},       32'(o_dato_a),  32'h0);
    chk({tag, "_b"},       32'(o_dato_b),  32'h0);
    chk({tag, "_op"},      32'(o_opcode),  32'h0);
    chk({tag, "_valid"},   32'(o_valid),   32'h0);
    chk({tag, "_timeout"}, 32'(o_timeout), 32'h0);
  endtask

  // Monitor: every output event must match the oldest pending expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL valid_unexpected: actual o_valid=1 at cycle %0d, required no event", cyc);
        end else begin
          e = sb.pop_front();
          chk("valid_kind",  32'(e.is_frame), 32'd1);
          chk("valid_cycle", 32'(cyc),        32'(e.cyc));
          chk("valid_a",     32'(o_dato_a),   32'(e.a));
          chk("valid_b",     32'(o_dato_b),   32'(e.b));
          chk("valid_op",    32'(o_opcode),   32'(e.op));
        end
      end
      if (o_timeout) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL timeout_unexpected: actual o_timeout=1 at cycle %0d, required no event", cyc);
        end else begin
          e = sb.pop_front();
          chk("timeout_kind",  32'(e.is_frame), 32'd0);
          chk("timeout_cycle", 32'(cyc),        32'(e.cyc));
        end
      end
    end
  end

  // All stimulus tasks are entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    data = b;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    data = 8'hFF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called in the cycle the opcode byte is driven: valid shows one cycle later.
  task automatic exp_frame(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    sb.push_back('{is_frame: 1'b1, a: a, b: b, op: op, cyc: cyc + 1});
  endtask

  // Called in the cycle the lone byte is driven: timeout shows TIMEOUT+1 later.
  task automatic exp_timeout();
    sb.push_back('{is_frame: 1'b0, a: 8'h0, b: 8'h0, op: 6'h0, cyc: cyc + TIMEOUT + 1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b0;
    done = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);
    chk_outs_zero("in_reset");
    rst = 1'b1;
    @(negedge clk);
    chk_outs_zero("after_reset");

    // Basic frame, 10-cycle spacing; outputs untouched until the frame completes.
    send_byte(8'h12); idle(9);
    chk("a_hold_after_byte1", 32'(o_dato_a), 32'h0);
    send_byte(8'h34); idle(9);
    chk("a_hold_after_byte2", 32'(o_dato_a), 32'h0);
    chk("b_hold_after_byte2", 32'(o_dato_b), 32'h0);
    exp_frame(8'h12, 8'h34, 6'h20);
    send_byte(8'h20); idle(9);

    // Upper opcode bits dropped; previous frame held while the next arrives.
    send_byte(8'h3C); idle(4);
    send_byte(8'h4D); idle(4);
    exp_frame(8'h3C, 8'h4D, 6'h22);
    send_byte(8'hE2); idle(5);
    send_byte(8'h05); idle(4);
    send_byte(8'h07); idle(4);
    chk("hold_a", 32'(o_dato_a), 32'h3C);
    chk("hold_b", 32'(o_dato_b), 32'h4D);
    chk("hold_op", 32'(o_opcode), 32'h22);
    exp_frame(8'h05, 8'h07, 6'h20);
    send_byte(8'h20); idle(5);
    chk("stable_a", 32'(o_dato_a), 32'h05);

    // Lone byte then a long gap: timeout, stale byte never reaches the ALU.
    exp_timeout();
    send_byte(8'hAA); idle(25);
    chk("timeout_leaves_a", 32'(o_dato_a), 32'h05);
    send_byte(8'h01); idle(4);
    send_byte(8'h02); idle(4);
    exp_frame(8'h01, 8'h02, 6'h20);
    send_byte(8'h20); idle(5);

    // Bytes spaced exactly TIMEOUT cycles apart: last allowed slot, accepted.
    send_byte(8'h31); idle(TIMEOUT - 1);
    send_byte(8'h32); idle(TIMEOUT - 1);
    exp_frame(8'h31, 8'h32, 6'h33);
    send_byte(8'h33); idle(5);

    // One cycle too late: timeout fires and the late byte starts a new frame.
    exp_timeout();
    send_byte(8'h40); idle(TIMEOUT);
    send_byte(8'h41); idle(4);
    send_byte(8'h42); idle(4);
    exp_frame(8'h41, 8'h42, 6'h03);
    send_byte(8'h03); idle(5);

    // Byte during the VALID cycle becomes the next operand A.
    send_byte(8'h0F); idle(4);
    send_byte(8'h10); idle(4);
    exp_frame(8'h0F, 8'h10, 6'h21);
    send_byte(8'h21);
    send_byte(8'h55); idle(3);
    send_byte(8'h66); idle(3);
    exp_frame(8'h55, 8'h66, 6'h24);
    send_byte(8'h24); idle(5);

    // Asynchronous reset mid-frame: immediate clear, partial byte discarded.
    send_byte(8'h99); idle(3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_outs_zero("async_reset");
    #1 rst = 1'b1;
    @(negedge clk);
    send_byte(8'h11); idle(4);
    send_byte(8'h22); idle(4);
    exp_frame(8'h11, 8'h22, 6'h03);
    send_byte(8'h03); idle(30);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
